cga_pixel_shift: RTL

CGA_PIXEL_SHIFT -- requirements
Module: cga_pixel_shift

---
 rtl/cga_pixel_shift.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cga_pixel_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cga_pixel_shift                                                |
// | Brief   : CGA pixel serializer for text, 320 and 640 graphics cells,     |
// |           with CRTC timing aligned to the pixel stream.                  |
// |           Optional sticky underrun flag: define CGA_SHIFT_UNDERRUN_EN.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cga_pixel_shift (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_en,
   input  logic       load,
   input  logic [7:0] vram_d0,
   input  logic [7:0] vram_d1,
   input  logic [7:0] font_data,
   input  logic       grph_mode,
   input  logic       mode_640,
   input  logic       de_in,
   input  logic       cursor_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [7:0] att_byte,
   output logic       pix_in,
   output logic       c0,
   output logic       c1,
   output logic       pix_640,
   output logic       display_enable,
   output logic       cursor,
   output logic       hsync,
`ifdef CGA_SHIFT_UNDERRUN_EN
   output logic       underrun,
`endif
   output logic       vsync
);

   localparam logic [4:0] c_CNT_CELL_8  = 5'd8;
   localparam logic [4:0] c_CNT_CELL_16 = 5'd16;

   logic [15:0] r_shift;
   logic [4:0]  r_count;
   logic        r_cell_grph;
   logic        r_cell_640;

   logic [15:0] w_shift_nxt;
   logic [4:0]  w_count_nxt;

   // Next shifter/count for an enabled pixel cycle; load always wins over shifting.
   always_comb begin
      w_shift_nxt = r_shift;
      w_count_nxt = r_count;
      if (load) begin
         if (grph_mode) begin
            w_shift_nxt = {vram_d0, vram_d1};
            w_count_nxt = mode_640 ? c_CNT_CELL_16 : c_CNT_CELL_8;
         end else begin
            w_shift_nxt = {font_data, 8'h00};
            w_count_nxt = c_CNT_CELL_8;
         end
      end else if (r_count != 5'd0) begin
         w_count_nxt = r_count - 5'd1;
         if (r_count == 5'd1) begin
            w_shift_nxt = 16'h0000;
         end else if (r_cell_grph && !r_cell_640) begin
            w_shift_nxt = {r_shift[13:0], 2'b00};
         end else begin
            w_shift_nxt = {r_shift[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_shift        <= 16'h0000;
         r_count        <= 5'd0;
         r_cell_grph    <= 1'b0;
         r_cell_640     <= 1'b0;
         att_byte       <= 8'h00;
         cursor         <= 1'b0;
         display_enable <= 1'b0;
         hsync          <= 1'b0;
         vsync          <= 1'b0;
      end else if (pix_en) begin
         r_shift        <= w_shift_nxt;
         r_count        <= w_count_nxt;
         display_enable <= de_in;
         hsync          <= hsync_in;
         vsync          <= vsync_in;
         if (load) begin
            r_cell_grph <= grph_mode;
            r_cell_640  <= mode_640;
            cursor      <= cursor_in;
            if (!grph_mode) begin
               att_byte <= vram_d1;
            end
         end
      end
   end

   // Pixel taps follow the mode captured with the cell, not the live mode inputs.
   always_comb begin
      pix_in  = 1'b0;
      c0      = 1'b0;
      c1      = 1'b0;
      pix_640 = 1'b0;
      if (!r_cell_grph) begin
         pix_in = r_shift[15];
      end else if (r_cell_640) begin
         pix_640 = r_shift[15];
      end else begin
         c1 = r_shift[15];
         c0 = r_shift[14];
      end
   end

`ifdef CGA_SHIFT_UNDERRUN_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         underrun <= 1'b0;
      end else if (pix_en && !load && (r_count == 5'd0) && de_in) begin
         underrun <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire
